// File: rtl/kgp_pkg.sv
// Shared KGP-RISC definitions: sequencer states, PC control codes and
// decoder instruction classes.
package kgp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_UPDATE = 3'd4,
    ST_HALT   = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  localparam logic [3:0] PC_SEQ = 4'b0000;
  localparam logic [3:0] PC_REG = 4'b0001;
  localparam logic [3:0] PC_JMP = 4'b0010;

  localparam logic [2:0] CLS_SEQ   = 3'b000;
  localparam logic [2:0] CLS_JREG  = 3'b001;
  localparam logic [2:0] CLS_JIMM  = 3'b010;
  localparam logic [2:0] CLS_JCOND = 3'b011;
  localparam logic [2:0] CLS_HALT  = 3'b100;

  // Classes 101..111 have no defined behaviour.
  function automatic logic is_illegal(input logic [2:0] cls);
    is_illegal = cls[2] && (cls != CLS_HALT);
  endfunction

  function automatic logic [3:0] pc_code(input logic [2:0] cls, input logic taken);
    case (cls)
      CLS_JREG:  pc_code = PC_REG;
      CLS_JIMM:  pc_code = PC_JMP;
      CLS_JCOND: pc_code = taken ? PC_JMP : PC_SEQ;
      default:   pc_code = PC_SEQ;
    endcase
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts FETCH cycles without an imem ack; flags the cycle whose
// increment would reach MAX_WAIT.
module fetch_timeout_counter #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_c
);

  localparam int unsigned CW = 8;

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired_c = en_i && (cnt_q == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// KGP-RISC fetch/decode/execute/update sequencer; sole driver of the PC
// enable and PC control code. Every output is a flop.
module fetch_sequencer
  import kgp_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_load,
  input  logic [2:0]       instr_class,
  input  logic             branch_taken,
  input  logic             exec_done,
  output logic             pc_en,
  output logic [3:0]       pc_control,
  output logic             halted,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [2:0]       class_q;
  logic             imem_req_q, ir_load_q, pc_en_q, halted_q, trap_q;
  logic [3:0]       pc_control_q;
  logic [CNT_W-1:0] retired_q;
  logic             wait_clr_c, wait_en_c, wait_expired_c;

  assign wait_clr_c = (state_q != ST_FETCH);
  assign wait_en_c  = (state_q == ST_FETCH) && !imem_ack;

  fetch_timeout_counter #(.MAX_WAIT(MAX_WAIT)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wait_clr_c),
    .en_i      (wait_en_c),
    .expired_c (wait_expired_c)
  );

  // Next-state decode; HALT and TRAP only leave through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!stall) state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack)            state_d = ST_DECODE;
        else if (wait_expired_c) state_d = ST_TRAP;
      end
      ST_DECODE: begin
        if (instr_class == CLS_HALT)     state_d = ST_HALT;
        else if (is_illegal(instr_class)) state_d = ST_TRAP;
        else                             state_d = ST_EXEC;
      end
      ST_EXEC:   if (exec_done) state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = state_q;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      class_q      <= CLS_SEQ;
      imem_req_q   <= 1'b0;
      ir_load_q    <= 1'b0;
      pc_en_q      <= 1'b0;
      pc_control_q <= PC_SEQ;
      halted_q     <= 1'b0;
      trap_q       <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      imem_req_q   <= (state_d == ST_FETCH);
      ir_load_q    <= (state_q == ST_FETCH) && imem_ack;
      pc_en_q      <= (state_d == ST_UPDATE);
      pc_control_q <= (state_d == ST_UPDATE) ? pc_code(class_q, branch_taken) : PC_SEQ;
      if (state_q == ST_DECODE) class_q <= instr_class;
      if (state_d == ST_UPDATE) retired_q <= retired_q + CNT_W'(1);
      if (state_d == ST_HALT)   halted_q <= 1'b1;
      if (state_d == ST_TRAP)   trap_q <= 1'b1;
    end
  end

  assign imem_req   = imem_req_q;
  assign ir_load    = ir_load_q;
  assign pc_en      = pc_en_q;
  assign pc_control = pc_control_q;
  assign halted     = halted_q;
  assign trap       = trap_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: an open-loop driver schedules each
// instruction's cycles and queues expected events; a monitor checks them.
module tb_fetch_sequencer;
  import kgp_pkg::*;

  localparam int unsigned MW = 15;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall = 1'b1;
  logic          imem_ack = 1'b0;
  logic          branch_taken = 1'b0;
  logic          exec_done = 1'b0;
  logic [2:0]    instr_class = 3'b000;
  logic          imem_req, ir_load, pc_en, halted, trap;
  logic [3:0]    pc_control;
  logic [CW-1:0] retired;

  fetch_sequencer #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .ir_load      (ir_load),
    .instr_class  (instr_class),
    .branch_taken (branch_taken),
    .exec_done    (exec_done),
    .pc_en        (pc_en),
    .pc_control   (pc_control),
    .halted       (halted),
    .trap         (trap),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [3:0]    code;
    logic [CW-1:0] ret;
  } upd_t;

  upd_t          uq[$];
  int            iq[$];
  int            errors = 0;
  int            checks = 0;
  logic          exp_req = 1'b0, exp_halt = 1'b0, exp_trap = 1'b0;
  logic [CW-1:0] ret_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference PC code straight from the class table.
  function automatic logic [3:0] exp_code(input logic [2:0] c, input logic b);
    case (c)
      3'd1:    return 4'd1;
      3'd2:    return 4'd2;
      3'd3:    return b ? 4'd2 : 4'd0;
      default: return 4'd0;
    endcase
  endfunction

  upd_t mon_e;
  int   mon_i;

  always @(negedge clk) begin
    if (!rst) begin
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      chk("halted", 32'(halted), 32'(exp_halt));
      chk("trap", 32'(trap), 32'(exp_trap));
      if (pc_en) begin
        if (uq.size() == 0) chk("pc_en_unexpected", 32'(pc_en), 32'd0);
        else begin
          mon_e = uq.pop_front();
          chk("pc_en_cycle", 32'(cyc), 32'(mon_e.cyc));
          chk("pc_control", 32'(pc_control), 32'(mon_e.code));
          chk("retired", 32'(retired), 32'(mon_e.ret));
        end
      end else begin
        chk("pc_control_idle", 32'(pc_control), 32'd0);
        if (uq.size() != 0 && uq[0].cyc < cyc) begin
          void'(uq.pop_front());
          chk("pc_en_missing", 32'(pc_en), 32'd1);
        end
      end
      if (ir_load) begin
        if (iq.size() == 0) chk("ir_load_unexpected", 32'(ir_load), 32'd0);
        else begin
          mon_i = iq.pop_front();
          chk("ir_load_cycle", 32'(cyc), 32'(mon_i));
        end
      end else if (iq.size() != 0 && iq[0] < cyc) begin
        void'(iq.pop_front());
        chk("ir_load_missing", 32'(ir_load), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs that the current state must ignore get random values.
  task automatic noise();
    imem_ack     = 1'($urandom);
    exec_done    = 1'($urandom);
    branch_taken = 1'($urandom);
    instr_class  = 3'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_ir_load", 32'(ir_load), 32'd0);
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    chk("rst_pc_control", 32'(pc_control), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_trap", 32'(trap), 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
    uq.delete();
    iq.delete();
    exp_req  = 1'b0;
    exp_halt = 1'b0;
    exp_trap = 1'b0;
    ret_m    = '0;
    stall    = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One instruction: s stall cycles, a ack-wait cycles, d done-wait cycles.
  task automatic issue(input int s, input int a, input int d, input logic [2:0] c, input logic b);
    repeat (s) begin noise(); stall = 1'b1; exp_req = 1'b0; tick(); end
    noise(); stall = 1'b0; exp_req = 1'b0; tick();
    repeat (a) begin noise(); stall = 1'($urandom); imem_ack = 1'b0; exp_req = 1'b1; tick(); end
    noise(); stall = 1'($urandom); imem_ack = 1'b1; exp_req = 1'b1; tick();
    noise(); stall = 1'($urandom); instr_class = c; exp_req = 1'b0; iq.push_back(cyc + 0); tick();
    if (c[2]) begin
      if (c == 3'b100) exp_halt = 1'b1;
      else exp_trap = 1'b1;
      repeat (8) begin noise(); stall = 1'b0; tick(); end
      return;
    end
    repeat (d) begin noise(); stall = 1'($urandom); exec_done = 1'b0; tick(); end
    noise(); stall = 1'($urandom); exec_done = 1'b1; branch_taken = b; tick();
    noise(); stall = 1'($urandom);
    ret_m = ret_m + 1'b1;
    uq.push_back('{cyc, exp_code(c, b), ret_m});
    tick();
  endtask

  initial begin
    #2;
    do_reset();

    // Straight-line code, then control flow and handshake waits.
    repeat (3) issue(0, 0, 0, 3'b000, 1'b0);
    issue(0, 0, 0, 3'b011, 1'b1);
    issue(0, 0, 0, 3'b011, 1'b0);
    issue(0, 0, 0, 3'b001, 1'b0);
    issue(0, 3, 2, 3'b010, 1'b0);
    issue(6, 0, 0, 3'b000, 1'b0);

    for (int i = 0; i < 20; i++)
      issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
            3'($urandom_range(0, 3)), 1'($urandom));

    // Abort in EXEC: reset must clear everything with no PC update.
    noise(); stall = 1'b0; exp_req = 1'b0; tick();
    noise(); imem_ack = 1'b1; exp_req = 1'b1; tick();
    noise(); instr_class = 3'b000; exp_req = 1'b0; iq.push_back(cyc + 0); tick();
    noise(); exec_done = 1'b0;
    #2;
    do_reset();
    repeat (4) begin noise(); stall = 1'b1; tick(); end

    repeat (17) issue(0, 0, 0, 3'b000, 1'b0);
    stall = 1'b1;
    chk("retired_wrap", 32'(retired), 32'd1);
    tick();

    issue(0, 1, 0, 3'b110, 1'b0);
    chk("trap_illegal", 32'(trap), 32'd1);
    do_reset();

    noise(); stall = 1'b0; exp_req = 1'b0; tick();
    repeat (MW) begin noise(); imem_ack = 1'b0; exp_req = 1'b1; tick(); end
    exp_trap = 1'b1; exp_req = 1'b0;
    repeat (6) begin noise(); tick(); end
    chk("trap_timeout", 32'(trap), 32'd1);
    chk("req_after_timeout", 32'(imem_req), 32'd0);
    do_reset();

    issue(0, 0, 0, 3'b100, 1'b0);
    chk("halted_final", 32'(halted), 32'd1);
    chk("pending_updates", 32'(uq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
